// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial BCD adder/subtractor controller.
// One 4-bit add stage with decimal correction, LSD first.
module bcd_serial_addsub_ctrl #(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              cout,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [4*NDIG-1:0] a_q, b_q;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              mode_q;
  logic              carry_q, carry_d;
  logic [1:0]        cnt_q;
  logic [3:0]        a_dig, b_dig, bd, dig;
  logic [4:0]        sum;
  logic              bad, last;

  // Select current digit, flag non-BCD operands, run the shared add stage
  always_comb begin
    a_dig    = '0;
    b_dig    = '0;
    bad      = 1'b0;
    shadow_d = shadow_q;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == i[1:0]) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
      if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
    bd  = mode_q ? (4'd9 - b_dig) : b_dig;
    sum = {1'b0, a_dig} + {1'b0, bd} + {4'b0, carry_q};
    if (sum > 5'd9) begin
      dig     = sum[3:0] + 4'd6;
      carry_d = 1'b1;
    end else begin
      dig     = sum[3:0];
      carry_d = 1'b0;
    end
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == i[1:0])
        shadow_d[4*i +: 4] = dig;
    end
    last = (cnt_q == 2'(NDIG - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (bad || last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand latch, digit datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      result   <= '0;
      cout     <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            carry_q <= mode;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + 2'd1;
          shadow_q <= shadow_d;
          if (bad) begin
            result <= '0;
            cout   <= 1'b0;
            err    <= 1'b1;
          end else if (last) begin
            result <= shadow_d;
            cout   <= carry_d;
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Directed bench for bcd_serial_addsub_ctrl, NDIG=2.
// Hand-computed vectors checked with immediate assertions.
module tb_bcd_serial_addsub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] a, b;
  logic       busy, done, cout, err;
  logic [7:0] result;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_serial_addsub_ctrl #(.NDIG(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op and follow it to done, checking latency and outputs
  task automatic run_op(input string tag,
                        input logic [7:0] ia,
                        input logic [7:0] ib,
                        input logic im,
                        input logic [7:0] eres,
                        input logic ecout,
                        input logic eerr,
                        input int elat);
    int lat;
    @(negedge clk);
    a = ia; b = ib; mode = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy@T0"}, busy, 1);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " result"}, result, eres);
    chk({tag, " cout"}, cout, ecout);
    chk({tag, " err"}, err, eerr);
    chk({tag, " busy@done"}, busy, 1);
    @(posedge clk); #1;
    chk({tag, " done low after"}, done, 0);
    chk({tag, " busy low after"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, " result held"}, result, eres);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset cout", cout, 0);
    chk("reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add45+38", 8'h45, 8'h38, 1'b0, 8'h83, 1'b0, 1'b0, 2);
    run_op("add99+99", 8'h99, 8'h99, 1'b0, 8'h98, 1'b1, 1'b0, 2);
    run_op("sub72-35", 8'h72, 8'h35, 1'b1, 8'h37, 1'b1, 1'b0, 2);
    run_op("sub35-72", 8'h35, 8'h72, 1'b1, 8'h63, 1'b0, 1'b0, 2);
    run_op("sub00-01", 8'h00, 8'h01, 1'b1, 8'h99, 1'b0, 1'b0, 2);
    run_op("bad a3A", 8'h3A, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    run_op("add12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 2);
    run_op("bad bF0", 8'h20, 8'hF0, 1'b1, 8'h00, 1'b0, 1'b1, 1);
    run_op("add50+50", 8'h50, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0, 2);

    // start held high through CALC and DONE with new operands
    @(negedge clk);
    a = 8'h45; b = 8'h38; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("ign busy@T0", busy, 1);
    @(negedge clk);
    a = 8'h99; b = 8'h99; mode = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("ign result", result, 8'h83);
        chk("ign cout", cout, 0);
      end
    end
    chk("ign busy after DONE", busy, 0);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("ign done count", ndone, 1);
    chk("ign result held", result, 8'h83);

    // reset pulsed in the middle of CALC
    @(negedge clk);
    a = 8'h99; b = 8'h01; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst busy pre", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst cout", cout, 0);
    chk("rst err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("rst no done", ndone, 0);
    run_op("post rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
